// File: rtl/player_turn_ctrl.sv
// player_turn_ctrl
// Game-start and turn controller for the multi-player Mastermind machine.
// Picks the first code setter from the enter buttons, then walks every round
// through code entry (SETUP) and guessing (PLAY), rotating the setter role
// between rounds and stopping in OVER after the last round.

module player_turn_ctrl #(
  parameter  int NUM_PLAYERS = 2,
  parameter  int NUM_ROUNDS  = 4,
  parameter  int TIE_MODE    = 0,
  localparam int PW          = $clog2(NUM_PLAYERS),
  localparam int RW          = $clog2(NUM_ROUNDS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_PLAYERS-1:0] enter,
  input  logic                   code_loaded,
  input  logic                   round_done,
  input  logic                   new_game,
  output logic                   started,
  output logic [PW-1:0]          setter_id,
  output logic [NUM_PLAYERS-1:0] setter_onehot,
  output logic                   take_code,
  output logic                   guessing,
  output logic [RW-1:0]          round_num,
  output logic                   game_over
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PLAY  = 3'd2,
    NEXT  = 3'd3,
    OVER  = 3'd4
  } state_e;

  localparam logic [RW-1:0] LAST_ROUND  = RW'(NUM_ROUNDS - 1);
  localparam logic [PW-1:0] LAST_PLAYER = PW'(NUM_PLAYERS - 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   setter_q, setter_d;
  logic [RW-1:0]   round_q, round_d;

  logic [PW-1:0]   lowIdx;
  logic            anyPress;
  logic            onePress;
  logic            acceptPress;

  // Find the lowest pressed button and decide whether the press pattern may start a game
  always_comb begin
    lowIdx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (enter[i]) begin
        lowIdx = PW'(i);
      end
    end
    anyPress    = |enter;
    onePress    = anyPress && ((enter & (enter - NUM_PLAYERS'(1))) == '0);
    acceptPress = onePress || (anyPress && (TIE_MODE == 1));
  end

  // Next-state logic; new_game overrides every other transition
  always_comb begin
    state_d  = state_q;
    setter_d = setter_q;
    round_d  = round_q;
    if (new_game) begin
      state_d  = IDLE;
      setter_d = '0;
      round_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acceptPress) begin
            state_d  = SETUP;
            setter_d = lowIdx;
            round_d  = '0;
          end
        end
        SETUP: begin
          if (code_loaded) begin
            state_d = PLAY;
          end
        end
        PLAY: begin
          if (round_done) begin
            if (round_q == LAST_ROUND) begin
              state_d = OVER;
            end else begin
              // Rotation happens on entry to NEXT so NEXT already shows the new setter and round
              state_d  = NEXT;
              setter_d = (setter_q == LAST_PLAYER) ? '0 : setter_q + PW'(1);
              round_d  = round_q + RW'(1);
            end
          end
        end
        NEXT: begin
          state_d = SETUP;
        end
        OVER: begin
          state_d = OVER;
        end
        default: begin
          state_d  = IDLE;
          setter_d = '0;
          round_d  = '0;
        end
      endcase
    end
  end

  // State, setter and round registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      setter_q <= '0;
      round_q  <= '0;
    end else begin
      state_q  <= state_d;
      setter_q <= setter_d;
      round_q  <= round_d;
    end
  end

  // Moore output decode from the registered state only
  always_comb begin
    started   = (state_q != IDLE);
    take_code = (state_q == SETUP);
    guessing  = (state_q == PLAY);
    game_over = (state_q == OVER);
    setter_id = setter_q;
    round_num = round_q;
    setter_onehot = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      setter_onehot[i] = started && (setter_q == PW'(i));
    end
  end

endmodule

// File: tb/tb_player_turn_ctrl.sv
// Testbench for player_turn_ctrl: two instances (ties ignored / lowest index
// wins) with three players and two rounds, driven by a vector table, a few
// hand-written reset sequences and random stimulus against a reference model.

module tb_player_turn_ctrl;

  localparam int NP = 3;
  localparam int NR = 2;

  typedef struct packed {
    logic       started;
    logic [1:0] sid;
    logic [2:0] oh;
    logic       take;
    logic       guess;
    logic [1:0] rnd;
    logic       over;
  } outs_t;

  typedef struct {
    logic [2:0] enter;
    logic       cl;
    logic       rd;
    logic       ng;
    outs_t      exp0;
    outs_t      exp1;
  } vec_t;

  localparam int PH_IDLE  = 0;
  localparam int PH_SETUP = 1;
  localparam int PH_PLAY  = 2;
  localparam int PH_NEXT  = 3;
  localparam int PH_OVER  = 4;

  logic       clk = 1'b0;
  logic       rstN;
  logic [2:0] enterIn;
  logic       clIn, rdIn, ngIn;

  logic       started0, take0, guess0, over0;
  logic [1:0] sid0, rnd0;
  logic [2:0] oh0;
  logic       started1, take1, guess1, over1;
  logic [1:0] sid1, rnd1;
  logic [2:0] oh1;
  outs_t      act0, act1;

  int vecCount  = 0;
  int missCount = 0;

  int mPhase[2];
  int mSetter[2];
  int mRound[2];

  vec_t tbl[$];

  // Free-running clock
  always #5 clk = ~clk;

  player_turn_ctrl #(.NUM_PLAYERS(NP), .NUM_ROUNDS(NR), .TIE_MODE(0)) dut0 (
    .clk(clk), .reset(rstN), .enter(enterIn), .code_loaded(clIn),
    .round_done(rdIn), .new_game(ngIn), .started(started0), .setter_id(sid0),
    .setter_onehot(oh0), .take_code(take0), .guessing(guess0),
    .round_num(rnd0), .game_over(over0)
  );

  player_turn_ctrl #(.NUM_PLAYERS(NP), .NUM_ROUNDS(NR), .TIE_MODE(1)) dut1 (
    .clk(clk), .reset(rstN), .enter(enterIn), .code_loaded(clIn),
    .round_done(rdIn), .new_game(ngIn), .started(started1), .setter_id(sid1),
    .setter_onehot(oh1), .take_code(take1), .guessing(guess1),
    .round_num(rnd1), .game_over(over1)
  );

  assign act0 = {started0, sid0, oh0, take0, guess0, rnd0, over0};
  assign act1 = {started1, sid1, oh1, take1, guess1, rnd1, over1};

  function automatic outs_t mkOut(input logic st, input int sid, input logic [2:0] oh,
                                  input logic take, input logic guess, input int rnd,
                                  input logic over);
    outs_t o;
    o.started = st;
    o.sid     = 2'(sid);
    o.oh      = oh;
    o.take    = take;
    o.guess   = guess;
    o.rnd     = 2'(rnd);
    o.over    = over;
    return o;
  endfunction

  task automatic addRow(input logic [2:0] e, input logic cl, input logic rd, input logic ng,
                        input outs_t x0, input outs_t x1);
    vec_t v;
    v.enter = e; v.cl = cl; v.rd = rd; v.ng = ng; v.exp0 = x0; v.exp1 = x1;
    tbl.push_back(v);
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mPhase[k] = PH_IDLE; mSetter[k] = 0; mRound[k] = 0;
    end
  endtask

  // Game rules applied to one clock edge for the instance with tie policy k
  task automatic modelStep(input int k);
    int presses;
    int lowest;
    presses = 0;
    lowest  = -1;
    for (int i = 0; i < NP; i++) begin
      if (enterIn[i]) begin
        presses++;
        if (lowest < 0) lowest = i;
      end
    end
    if (ngIn) begin
      mPhase[k] = PH_IDLE; mSetter[k] = 0; mRound[k] = 0;
    end else if (mPhase[k] == PH_IDLE) begin
      if (presses == 1 || (presses > 1 && k == 1)) begin
        mPhase[k] = PH_SETUP; mSetter[k] = lowest; mRound[k] = 0;
      end
    end else if (mPhase[k] == PH_SETUP) begin
      if (clIn) mPhase[k] = PH_PLAY;
    end else if (mPhase[k] == PH_PLAY) begin
      if (rdIn) begin
        if (mRound[k] == NR - 1) begin
          mPhase[k] = PH_OVER;
        end else begin
          mPhase[k]  = PH_NEXT;
          mSetter[k] = (mSetter[k] + 1) % NP;
          mRound[k]  = mRound[k] + 1;
        end
      end
    end else if (mPhase[k] == PH_NEXT) begin
      mPhase[k] = PH_SETUP;
    end
  endtask

  function automatic outs_t modelOut(input int k);
    outs_t o;
    o.started = (mPhase[k] != PH_IDLE);
    o.sid     = 2'(mSetter[k]);
    o.oh      = o.started ? 3'(1 << mSetter[k]) : 3'b000;
    o.take    = (mPhase[k] == PH_SETUP);
    o.guess   = (mPhase[k] == PH_PLAY);
    o.rnd     = 2'(mRound[k]);
    o.over    = (mPhase[k] == PH_OVER);
    return o;
  endfunction

  task automatic applyStimulus(input logic [2:0] e, input logic cl, input logic rd, input logic ng);
    @(negedge clk);
    enterIn = e; clIn = cl; rdIn = rd; ngIn = ng;
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    #1;
  endtask

  task automatic checkOutput(input string name, input int dutIdx, input outs_t act, input outs_t exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s dut%0d: actual=%b required=%b (started,setter_id,onehot,take,guess,round,over)",
               name, dutIdx, act, exp);
    end
  endtask

  task automatic checkBoth(input string name);
    checkOutput(name, 0, act0, modelOut(0));
    checkOutput(name, 1, act1, modelOut(1));
  endtask

  initial begin
    outs_t idleO;
    idleO = '0;

    addRow(3'b110, 0, 0, 0, idleO,                              mkOut(1, 1, 3'b010, 1, 0, 0, 0));
    addRow(3'b000, 0, 0, 1, idleO,                              idleO);
    addRow(3'b100, 0, 0, 0, mkOut(1, 2, 3'b100, 1, 0, 0, 0),    mkOut(1, 2, 3'b100, 1, 0, 0, 0));
    addRow(3'b001, 0, 1, 0, mkOut(1, 2, 3'b100, 1, 0, 0, 0),    mkOut(1, 2, 3'b100, 1, 0, 0, 0));
    addRow(3'b000, 1, 1, 0, mkOut(1, 2, 3'b100, 0, 1, 0, 0),    mkOut(1, 2, 3'b100, 0, 1, 0, 0));
    addRow(3'b011, 1, 0, 0, mkOut(1, 2, 3'b100, 0, 1, 0, 0),    mkOut(1, 2, 3'b100, 0, 1, 0, 0));
    addRow(3'b000, 0, 1, 0, mkOut(1, 0, 3'b001, 0, 0, 1, 0),    mkOut(1, 0, 3'b001, 0, 0, 1, 0));
    addRow(3'b000, 0, 0, 0, mkOut(1, 0, 3'b001, 1, 0, 1, 0),    mkOut(1, 0, 3'b001, 1, 0, 1, 0));
    addRow(3'b000, 1, 0, 0, mkOut(1, 0, 3'b001, 0, 1, 1, 0),    mkOut(1, 0, 3'b001, 0, 1, 1, 0));
    addRow(3'b000, 0, 1, 0, mkOut(1, 0, 3'b001, 0, 0, 1, 1),    mkOut(1, 0, 3'b001, 0, 0, 1, 1));
    addRow(3'b111, 0, 0, 0, mkOut(1, 0, 3'b001, 0, 0, 1, 1),    mkOut(1, 0, 3'b001, 0, 0, 1, 1));
    addRow(3'b000, 0, 0, 1, idleO,                              idleO);
    addRow(3'b010, 0, 0, 0, mkOut(1, 1, 3'b010, 1, 0, 0, 0),    mkOut(1, 1, 3'b010, 1, 0, 0, 0));
    addRow(3'b000, 1, 0, 0, mkOut(1, 1, 3'b010, 0, 1, 0, 0),    mkOut(1, 1, 3'b010, 0, 1, 0, 0));
    addRow(3'b000, 0, 1, 1, idleO,                              idleO);

    enterIn = '0; clIn = 0; rdIn = 0; ngIn = 0;
    rstN = 1'b0;
    modelReset();
    #1;
    checkOutput("resetState", 0, act0, idleO);
    checkOutput("resetState", 1, act1, idleO);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].enter, tbl[i].cl, tbl[i].rd, tbl[i].ng);
      checkOutput($sformatf("row%0d", i), 0, act0, tbl[i].exp0);
      checkOutput($sformatf("row%0d", i), 1, act1, tbl[i].exp1);
    end

    // Reset pulled mid-PLAY must clear everything without a clock edge
    applyStimulus(3'b001, 0, 0, 0);
    applyStimulus(3'b000, 1, 0, 0);
    checkOutput("inPlay", 0, act0, mkOut(1, 0, 3'b001, 0, 1, 0, 0));
    @(negedge clk);
    #2;
    rstN = 1'b0;
    #1;
    modelReset();
    checkOutput("asyncReset", 0, act0, idleO);
    checkOutput("asyncReset", 1, act1, idleO);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(3'b000, 0, 0, 0);
    checkOutput("idleAfterReset", 0, act0, idleO);
    applyStimulus(3'b000, 1, 1, 0);
    checkOutput("idleAfterReset", 1, act1, idleO);

    // A press held through reset release starts the game on the first edge with reset high
    @(negedge clk);
    rstN = 1'b0;
    enterIn = 3'b001;
    modelReset();
    @(negedge clk);
    checkOutput("heldInReset", 0, act0, idleO);
    rstN = 1'b1;
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    #1;
    checkOutput("releaseEdge", 0, act0, mkOut(1, 0, 3'b001, 1, 0, 0, 0));
    checkOutput("releaseEdge", 1, act1, mkOut(1, 0, 3'b001, 1, 0, 0, 0));

    // Random play against the reference model
    for (int n = 0; n < 600; n++) begin
      logic [2:0] e;
      e = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      applyStimulus(e, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 29) == 0));
      checkBoth($sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/player_turn_ctrl.md
# player_turn_ctrl

Parametrised game-start and turn controller for the Mastermind machine, generalising the two-player start logic to NUM_PLAYERS players over multiple rounds. It arbitrates which player becomes the first code setter and sequences each round through code entry and guessing. After each round it rotates the setter role and ends the game after NUM_ROUNDS rounds. It sits between the player enter buttons and the code-storage and guess-compare datapath.

## Interface
- NUM_PLAYERS, 2, number of players; legal 2..8.
- NUM_ROUNDS, 4, rounds per game; legal 1..15.
- TIE_MODE, 0, simultaneous-press policy: 0 = ignore ties, 1 = lowest index wins.
- PW = $clog2(NUM_PLAYERS), RW = $clog2(NUM_ROUNDS+1): derived widths, not user-set.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- enter  input  NUM_PLAYERS  per-player enter buttons, level-sampled, already debounced and synchronised.
- code_loaded  input  1  single-cycle pulse from code storage: the setter's code is captured.
- round_done  input  1  single-cycle pulse from compare logic: the current round has finished.
- new_game  input  1  synchronous restart request.
- started  output  1  high whenever the state is not IDLE.
- setter_id  output  PW  index of the current code setter.
- setter_onehot  output  NUM_PLAYERS  one-hot decode of setter_id; all zero in IDLE.
- take_code  output  1  high in SETUP only.
- guessing  output  1  high in PLAY only.
- round_num  output  RW  current round, counted from 0.
- game_over  output  1  high in OVER only.

## Operation
The controller has five states: IDLE, SETUP, PLAY, NEXT and OVER.

- **IDLE**
  - Exactly one enter bit high: go to SETUP and load setter_id with that bit's index.
  - More than one bit high with TIE_MODE=0: stay in IDLE.
  - More than one bit high with TIE_MODE=1: go to SETUP with the lowest set index.
  - All bits zero: stay in IDLE.
- **SETUP**
  - code_loaded: go to PLAY.
  - enter and round_done are ignored.
- **PLAY**
  - round_done with round_num == NUM_ROUNDS-1: go to OVER.
  - round_done otherwise: go to NEXT.
  - code_loaded and enter are ignored.
- **NEXT** (one cycle)
  - setter_id <= (setter_id+1) mod NUM_PLAYERS, wrapping from NUM_PLAYERS-1 to 0.
  - round_num <= round_num+1.
  - Next state is SETUP.
- **OVER**
  - Holds until new_game; enter is ignored.
- **new_game**
  - Takes priority over every transition in every state.
  - Next state is IDLE, with setter_id=0 and round_num=0.
- Outputs are Moore, decoded only from the state, setter and round registers; there is no input-to-output combinational path.
- If the enter bits are held high after the game starts, they have no effect.

## Timing
- Asynchronous reset: state=IDLE, setter_id=0, round_num=0, and all outputs 0 (including setter_onehot=0), immediately and independent of clk.
- Reset release: the first transition happens on the first rising edge at which reset is high.
- enter arriving in IDLE: started, take_code and setter_* are valid one cycle after the sampling edge.
- code_loaded to guessing: 1 cycle.
- round_done to the next take_code: 2 cycles, passing through NEXT, where take_code=0 and guessing=0.
- round_done to game_over on the last round: 1 cycle.
- Simultaneous code_loaded and round_done: only the input relevant to the current state acts.
- Reset asserted mid-game aborts the game at once; no partial round state is kept.

## Test plan
- **Reset:** NUM_PLAYERS=3, drive reset=0 mid-PLAY -> all outputs 0 immediately; after release with enter=0, the controller stays in IDLE.
- **Single press:** enter=3'b100 -> one cycle later started=1, setter_id=2, setter_onehot=3'b100, take_code=1, round_num=0.
- **Tie handling:** enter=3'b110.
  - TIE_MODE=0 -> stays in IDLE.
  - TIE_MODE=1 -> setter_id=1.
- **Rotation and wrap:** NUM_PLAYERS=3, start with setter 2, then code_loaded followed by round_done -> guessing for one round; NEXT shows setter_id=0 and round_num=1; take_code=1 two cycles after round_done.
- **Game end:** NUM_ROUNDS=2, complete two rounds -> game_over=1 one cycle after the second round_done; enter is ignored; new_game -> IDLE with round_num=0 and setter_id=0.
- **Priority:** new_game and round_done in the same cycle during PLAY -> next state is IDLE, not NEXT.
